// File: rtl/mips_bus_pkg.sv
// -----------------------------------------------------------------------------
// mips_bus_pkg
// Shared types and widths for the MIPS instruction/data bus arbiter.
//   arb_state_t : arbiter FSM state (IDLE, GRANT_I, GRANT_D)
//   bus_req_t   : one latched memory-side transfer (address, command,
//                 write data, byte enables)
// -----------------------------------------------------------------------------
package mips_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic              read;
        logic              write;
        logic [DATA_W-1:0] writedata;
        logic [BE_W-1:0]   byteenable;
    } bus_req_t;

endpackage

// File: rtl/mips_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mips_bus_arbiter
// Two-port Avalon arbiter: a MIPS instruction port (read only) and a data
// port (read/write) share one Avalon master toward memory.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   i_*                 instruction slave port (address, read, waitrequest,
//                       readdata)
//   d_*                 data slave port (address, read, write, writedata,
//                       byteenable, waitrequest, readdata)
//   address ... readdata  memory-side Avalon master
//
// Behaviour: requests are sampled in IDLE, the winner's transfer is latched on
// entry to GRANT_I/GRANT_D and the master outputs come only from that latch.
// Completion (waitrequest low while granted) returns the FSM to IDLE, so every
// transfer is followed by one IDLE bubble.
//
// Configuration macro MIPS_BUS_ARB_RR_EN:
//   undefined : data has fixed priority; after HOLD_MAX back-to-back data
//               grants with instruction waiting, instruction wins once.
//   defined   : round-robin on contention; no streak counter, HOLD_MAX unused.
// -----------------------------------------------------------------------------
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    // instruction port
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    output logic              i_waitrequest,
    output logic [DATA_W-1:0] i_readdata,
    // data port
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [DATA_W-1:0] d_writedata,
    input  logic [BE_W-1:0]   d_byteenable,
    output logic              d_waitrequest,
    output logic [DATA_W-1:0] d_readdata,
    // memory master
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic [BE_W-1:0]   byteenable,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata
);

    arb_state_t state_q, state_d;
    bus_req_t   req_q, req_d;
    // 1 when the most recent grant went to the data port
    logic       last_data_q, last_data_d;

    logic       d_req;
    logic       win_data;

`ifdef MIPS_BUS_ARB_RR_EN
`else
    localparam int STREAK_W = $clog2(HOLD_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_HOLD = STREAK_W'(HOLD_MAX);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                other_pending;
`endif

    assign d_req = d_read | d_write;

    // Next-state, grant decision and transfer latch update
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        last_data_d = last_data_q;
        win_data    = 1'b0;
`ifdef MIPS_BUS_ARB_RR_EN
`else
        streak_d      = streak_q;
        other_pending = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (d_req || i_read) begin
                    if (d_req && i_read) begin
`ifdef MIPS_BUS_ARB_RR_EN
                        win_data = ~last_data_q;
`else
                        // data keeps priority until it has held the bus
                        // HOLD_MAX times in a row against a waiting fetch
                        win_data = ~((streak_q >= STREAK_HOLD) && last_data_q);
`endif
                    end else begin
                        win_data = d_req;
                    end

                    if (win_data) begin
                        state_d          = GRANT_D;
                        req_d.address    = d_address;
                        req_d.write      = d_write;
                        req_d.read       = d_read & ~d_write;
                        req_d.writedata  = d_writedata;
                        req_d.byteenable = d_byteenable;
                    end else begin
                        state_d          = GRANT_I;
                        req_d.address    = i_address;
                        req_d.write      = 1'b0;
                        req_d.read       = 1'b1;
                        req_d.writedata  = {DATA_W{1'b0}};
                        req_d.byteenable = {BE_W{1'b1}};
                    end
                    last_data_d = win_data;

`ifdef MIPS_BUS_ARB_RR_EN
`else
                    // streak = consecutive grants to the current winner
                    // while the loser was waiting; a switch restarts it
                    other_pending = win_data ? i_read : d_req;
                    if (!other_pending) begin
                        streak_d = {STREAK_W{1'b0}};
                    end else if (win_data == last_data_q) begin
                        if (streak_q < STREAK_HOLD) begin
                            streak_d = streak_q + STREAK_W'(1);
                        end else begin
                            streak_d = streak_q;
                        end
                    end else begin
                        streak_d = STREAK_W'(1);
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT_I, GRANT_D: begin
                // completion: drop the command so the bubble cycle is quiet
                if (!waitrequest) begin
                    state_d     = IDLE;
                    req_d.read  = 1'b0;
                    req_d.write = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d     = IDLE;
                req_d.read  = 1'b0;
                req_d.write = 1'b0;
            end
        endcase
    end

    // State, transfer latch and arbitration history registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            last_data_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            last_data_q <= last_data_d;
        end
    end

`ifdef MIPS_BUS_ARB_RR_EN
`else
    // Starvation-guard streak counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_q <= {STREAK_W{1'b0}};
        end else begin
            streak_q <= streak_d;
        end
    end
`endif

    // Master side comes only from the latch, so it is glitch-free and clears
    // asynchronously with reset.
    assign address    = req_q.address;
    assign read       = req_q.read;
    assign write      = req_q.write;
    assign writedata  = req_q.writedata;
    assign byteenable = req_q.byteenable;

    assign i_waitrequest = ~((state_q == GRANT_I) && !waitrequest);
    assign d_waitrequest = ~((state_q == GRANT_D) && !waitrequest);

    assign i_readdata = readdata;
    assign d_readdata = readdata;

endmodule

// File: doc/mips_bus_arbiter.md
MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 4, maximum back-to-back grants to one requester while the other waits.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
REQ-004 Instruction port (i_*), Avalon slave side:
- i_address  in  32
- i_read  in  1
- i_waitrequest  out  1
- i_readdata  out  32
REQ-005 Data port (d_*), Avalon slave side:
- d_address  in  32
- d_read  in  1
- d_write  in  1
- d_writedata  in  32
- d_byteenable  in  4
- d_waitrequest  out  1
- d_readdata  out  32
REQ-006 Memory side, Avalon master:
- address  out  32
- read  out  1
- write  out  1
- writedata  out  32
- byteenable  out  4
- waitrequest  in  1
- readdata  in  32

Function
REQ-007 The FSM SHALL have three states: IDLE, GRANT_I and GRANT_D.
REQ-008 In IDLE, any request (i_read, d_read or d_write) SHALL be sampled and the FSM SHALL move to a GRANT state on the next edge, giving 1 cycle of arbitration latency.
REQ-009 On entry to a GRANT state, the winner's address, command, writedata and byteenable SHALL be latched; all master outputs SHALL be driven only from these latches.
- Instruction grants SHALL latch byteenable=4'hF and writedata=0.
REQ-010 The master read/write SHALL be held high in the GRANT state until the cycle in which waitrequest=0 (completion); the FSM SHALL then return to IDLE.
- This gives at least 2 cycles per transfer and 1 bubble between transfers.
REQ-011 Requester waitrequest SHALL be 0 only in the completion cycle of its own granted transfer, and 1 in all other cycles, including IDLE.
REQ-012 i_readdata and d_readdata SHALL both equal readdata combinationally; a value is valid only when the matching waitrequest is 0 and the transfer is a read.
REQ-013 Default priority is fixed: data over instruction.
REQ-014 A streak counter SHALL count consecutive grants to the same requester while the other requester is pending.
- When the counter reaches HOLD_MAX, the next grant SHALL go to the other requester.
- The counter SHALL clear on any grant switch or when the other requester is not pending.
REQ-015 If d_read and d_write are both high, the transfer SHALL be treated as a write and the read SHALL be ignored.
REQ-016 If a requester deasserts its request mid-transfer (protocol violation), the latched transfer SHALL still complete and the completion waitrequest=0 SHALL still be issued.
REQ-017 Simultaneous completion and a new request SHALL NOT grant in the same cycle; the new request is granted from IDLE on the following edge.
REQ-018 read and write on the master side SHALL never be high together.

Reset
REQ-019 On reset assertion, outputs SHALL take these values immediately (asynchronous):
- FSM=IDLE, streak counter=0, latches cleared.
- address=0, read=0, write=0, writedata=0, byteenable=0.
- i_waitrequest=1, d_waitrequest=1.
REQ-020 A transfer in flight at reset SHALL be abandoned with no completion signalled to either requester.
REQ-021 After reset release, the first request SHALL be sampled on the first rising edge.

Configuration
REQ-022 Macro MIPS_BUS_ARB_RR_EN:
- Defined: round-robin arbitration; when both request in IDLE, the requester not granted last SHALL win; the last-granted flag resets to instruction, so data wins first.
- Undefined: fixed priority plus HOLD_MAX starvation guard as in REQ-013/REQ-014.
REQ-023 With MIPS_BUS_ARB_RR_EN defined, the streak counter SHALL be omitted and HOLD_MAX ignored.

Structure
REQ-024 Package mips_bus_pkg SHALL hold:
- the arb_state_t enum (IDLE, GRANT_I, GRANT_D);
- a bus_req_t struct (address, read, write, writedata, byteenable);
- constants ADDR_W=32, DATA_W=32, BE_W=4.
REQ-025 No sub-module is required; the FSM, latches and counter are implemented in a single module.

Verification
REQ-026 Instruction read alone:
- Stimulus: i_read, i_address=0xBFC00000, waitrequest=0, readdata=0x24020005.
- Response: master read high in cycle 2; i_waitrequest=0 with i_readdata=0x24020005 in cycle 2.
REQ-027 Contention:
- Stimulus: i_read and d_write (d_address=0x1000, d_writedata=0xDEADBEEF, d_byteenable=4'b0011) in the same cycle.
- Response: write completes first; the instruction read is granted after 1 IDLE bubble.
REQ-028 Wait states:
- Stimulus: waitrequest held high for 3 cycles during a d_read.
- Response: address and read stable for all 4 cycles; d_waitrequest low only in cycle 4; i_waitrequest remains 1.
REQ-029 Starvation guard (macro undefined, HOLD_MAX=4):
- Stimulus: d_read held continuously while i_read is pending.
- Response: the 5th grant goes to instruction.
- With the macro defined: grants alternate D, I, D, I.
REQ-030 Reset mid-transfer:
- Stimulus: reset asserted in cycle 2 of a write with waitrequest=1.
- Response: write=0 and d_waitrequest=1 immediately; after release, the FSM is in IDLE and no completion is seen.
REQ-031 Dual command:
- Stimulus: d_read and d_write both high.
- Response: master write=1 and read=0 throughout the transfer.
